// File: rtl/cv32e40p_breakage_monitor_mc_ft.sv
// Per-channel redundancy breakage monitor: saturating error counters with
// OK / DEGRADED / BROKEN classification, entry pulses and a broken-channel decode.
module cv32e40p_breakage_monitor_mc_ft #(
  parameter int N_CH               = 4,
  parameter int COUNT_BIT          = 8,
  parameter int INC_DEC_BIT        = 2,
  parameter int INCREMENT          = 1,
  parameter int DECREMENT          = 1,
  parameter int BREAKING_THRESHOLD = 3,
  parameter int STICKY             = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_CH-1:0]                        err_i,
  input  logic [N_CH-1:0]                        valid_i,
  input  logic [N_CH-1:0]                        clear_i,
  output logic [N_CH*COUNT_BIT-1:0]              count_o,
  output logic [N_CH-1:0]                        degraded_o,
  output logic [N_CH-1:0]                        broken_o,
  output logic [N_CH-1:0]                        fault_pulse_o,
  output logic                                   any_broken_o,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] broken_idx_o
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  // Wide enough that count + INCREMENT never overflows before saturation.
  localparam int W = COUNT_BIT + INC_DEC_BIT + 1;

  localparam logic [W-1:0]         INC_W   = W'(INCREMENT);
  localparam logic [W-1:0]         DEC_W   = W'(DECREMENT);
  localparam logic [W-1:0]         MAX_W   = W'((64'd1 << COUNT_BIT) - 64'd1);
  localparam logic [COUNT_BIT-1:0] MAX_C   = {COUNT_BIT{1'b1}};
  localparam logic [COUNT_BIT-1:0] THR_C   = COUNT_BIT'(BREAKING_THRESHOLD);
  localparam logic                 STICKY_B = (STICKY != 0);

  // State bit 1 is the broken flag and bit 0 the degraded flag, so both outputs are flop bits.
  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_DEGRADED = 2'b01;
  localparam logic [1:0] ST_BROKEN   = 2'b10;

  if (INCREMENT >= (2 ** INC_DEC_BIT)) begin : g_chk_inc
    $error("INCREMENT does not fit in INC_DEC_BIT bits");
  end
  if (DECREMENT >= (2 ** INC_DEC_BIT)) begin : g_chk_dec
    $error("DECREMENT does not fit in INC_DEC_BIT bits");
  end
  if (INCREMENT == 0) begin : g_chk_inc0
    $error("INCREMENT must be nonzero");
  end
  if (BREAKING_THRESHOLD == 0) begin : g_chk_thr0
    $error("BREAKING_THRESHOLD must be nonzero");
  end
  if (64'(BREAKING_THRESHOLD) > ((64'd1 << COUNT_BIT) - 64'd1)) begin : g_chk_thr
    $error("BREAKING_THRESHOLD exceeds counter range");
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [COUNT_BIT-1:0] count_q, count_d;
    logic [1:0]           state_q, state_d;
    logic                 pulse_q, pulse_d;
    logic [W-1:0]         count_w;

    always_comb begin
      count_w = W'(count_q);
      count_d = count_q;
      if (clear_i[gi]) begin
        count_d = '0;
      end else if (STICKY_B && (state_q == ST_BROKEN)) begin
        count_d = count_q;
      end else if (err_i[gi]) begin
        count_d = ((count_w + INC_W) > MAX_W) ? MAX_C : COUNT_BIT'(count_w + INC_W);
      end else if (valid_i[gi]) begin
        count_d = (count_w < DEC_W) ? '0 : COUNT_BIT'(count_w - DEC_W);
      end

      if (count_d >= THR_C) begin
        state_d = ST_BROKEN;
      end else if (count_d != '0) begin
        state_d = ST_DEGRADED;
      end else begin
        state_d = ST_OK;
      end

      pulse_d = (state_d == ST_BROKEN) && (state_q != ST_BROKEN);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        count_q <= '0;
        state_q <= ST_OK;
        pulse_q <= 1'b0;
      end else begin
        count_q <= count_d;
        state_q <= state_d;
        pulse_q <= pulse_d;
      end
    end

    assign count_o[gi*COUNT_BIT +: COUNT_BIT] = count_q;
    assign broken_o[gi]      = state_q[1];
    assign degraded_o[gi]    = state_q[0];
    assign fault_pulse_o[gi] = pulse_q;
  end

  assign any_broken_o = |broken_o;

  always_comb begin
    broken_idx_o = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (broken_o[i]) begin
        broken_idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_breakage_monitor_mc_ft.sv
// Directed vector bench for the breakage monitor: sticky default, non-sticky,
// and narrow saturating configurations driven from one stimulus table.
module tb_cv32e40p_breakage_monitor_mc_ft;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-DUT stimulus: 0 = default sticky, 1 = non-sticky, 2 = COUNT_BIT=2 non-sticky
  logic       rst_s [3];
  logic [3:0] err_s [3];
  logic [3:0] val_s [3];
  logic [3:0] clr_s [3];

  logic [31:0] cnt0, cnt1;
  logic [7:0]  cnt2;
  logic [3:0]  deg0, deg1, deg2, brk0, brk1, brk2, pls0, pls1, pls2;
  logic        any0, any1, any2;
  logic [1:0]  idx0, idx1, idx2;

  cv32e40p_breakage_monitor_mc_ft u_def (
    .clk(clk), .rst(rst_s[0]), .err_i(err_s[0]), .valid_i(val_s[0]), .clear_i(clr_s[0]),
    .count_o(cnt0), .degraded_o(deg0), .broken_o(brk0), .fault_pulse_o(pls0),
    .any_broken_o(any0), .broken_idx_o(idx0)
  );

  cv32e40p_breakage_monitor_mc_ft #(.STICKY(0)) u_ns (
    .clk(clk), .rst(rst_s[1]), .err_i(err_s[1]), .valid_i(val_s[1]), .clear_i(clr_s[1]),
    .count_o(cnt1), .degraded_o(deg1), .broken_o(brk1), .fault_pulse_o(pls1),
    .any_broken_o(any1), .broken_idx_o(idx1)
  );

  cv32e40p_breakage_monitor_mc_ft #(.COUNT_BIT(2), .BREAKING_THRESHOLD(3), .STICKY(0)) u_sat (
    .clk(clk), .rst(rst_s[2]), .err_i(err_s[2]), .valid_i(val_s[2]), .clear_i(clr_s[2]),
    .count_o(cnt2), .degraded_o(deg2), .broken_o(brk2), .fault_pulse_o(pls2),
    .any_broken_o(any2), .broken_idx_o(idx2)
  );

  typedef struct {
    int          dut;
    logic [3:0]  err;
    logic [3:0]  valid;
    logic [3:0]  clear;
    logic        rst;
    logic [31:0] cnt;
    logic [3:0]  deg;
    logic [3:0]  brk;
    logic [3:0]  pls;
    logic        any;
    logic [1:0]  idx;
    string       name;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void v(input int dut, input logic [3:0] err, input logic [3:0] valid,
                            input logic [3:0] clear, input logic rst, input logic [31:0] cnt,
                            input logic [3:0] deg, input logic [3:0] brk, input logic [3:0] pls,
                            input logic any, input logic [1:0] idx, input string name);
    vec_t t;
    t.dut = dut; t.err = err; t.valid = valid; t.clear = clear; t.rst = rst;
    t.cnt = cnt; t.deg = deg; t.brk = brk; t.pls = pls; t.any = any; t.idx = idx;
    t.name = name;
    vq.push_back(t);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [31:0] a_cnt;
    logic [3:0]  a_deg, a_brk, a_pls;
    logic        a_any;
    logic [1:0]  a_idx;

    // Default sticky instance
    v(0, 4'h0, 4'h0, 4'h0, 1, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "d_reset");
    v(0, 4'h2, 4'h0, 4'h0, 0, 32'h100,      4'h2, 4'h0, 4'h0, 0, 0, "d_c1_e1");
    v(0, 4'h2, 4'h0, 4'h0, 0, 32'h200,      4'h2, 4'h0, 4'h0, 0, 0, "d_c1_e2");
    v(0, 4'h2, 4'h0, 4'h0, 0, 32'h300,      4'h0, 4'h2, 4'h2, 1, 1, "d_c1_brk");
    v(0, 4'h0, 4'h0, 4'h0, 0, 32'h300,      4'h0, 4'h2, 4'h0, 1, 1, "d_c1_hold");
    v(0, 4'h0, 4'h0, 4'h2, 0, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "d_c1_clr");
    v(0, 4'h1, 4'h0, 4'h0, 0, 32'h1,        4'h1, 4'h0, 4'h0, 0, 0, "d_c0_e1");
    v(0, 4'h1, 4'h1, 4'h0, 0, 32'h2,        4'h1, 4'h0, 4'h0, 0, 0, "d_c0_e2v");
    v(0, 4'h0, 4'h1, 4'h0, 0, 32'h1,        4'h1, 4'h0, 4'h0, 0, 0, "d_c0_v1");
    v(0, 4'h0, 4'h1, 4'h0, 0, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "d_c0_v2");
    v(0, 4'h0, 4'h1, 4'h0, 0, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "d_c0_floor");
    v(0, 4'h4, 4'h0, 4'h0, 0, 32'h10000,    4'h4, 4'h0, 4'h0, 0, 0, "d_c2_e1");
    v(0, 4'h4, 4'h0, 4'h0, 0, 32'h20000,    4'h4, 4'h0, 4'h0, 0, 0, "d_c2_e2");
    v(0, 4'h4, 4'h0, 4'h0, 0, 32'h30000,    4'h0, 4'h4, 4'h4, 1, 2, "d_c2_brk");
    for (int i = 0; i < 10; i++)
      v(0, 4'h0, 4'h4, 4'h0, 0, 32'h30000,  4'h0, 4'h4, 4'h0, 1, 2, "d_c2_frozen");
    v(0, 4'h4, 4'h0, 4'h0, 0, 32'h30000,    4'h0, 4'h4, 4'h0, 1, 2, "d_c2_frz_err");
    v(0, 4'h0, 4'h0, 4'h4, 0, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "d_c2_clr");
    v(0, 4'h1, 4'h0, 4'h0, 0, 32'h1,        4'h1, 4'h0, 4'h0, 0, 0, "d_ce_e1");
    v(0, 4'h1, 4'h0, 4'h0, 0, 32'h2,        4'h1, 4'h0, 4'h0, 0, 0, "d_ce_e2");
    v(0, 4'h1, 4'h0, 4'h1, 0, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "d_ce_clr_err");
    v(0, 4'h0, 4'h0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "d_ce_idle");
    v(0, 4'hA, 4'h0, 4'h0, 0, 32'h01000100, 4'hA, 4'h0, 4'h0, 0, 0, "d_31_e1");
    v(0, 4'hA, 4'h0, 4'h0, 0, 32'h02000200, 4'hA, 4'h0, 4'h0, 0, 0, "d_31_e2");
    v(0, 4'hA, 4'h0, 4'h0, 0, 32'h03000300, 4'h0, 4'hA, 4'hA, 1, 1, "d_31_brk");
    v(0, 4'hF, 4'hF, 4'h0, 1, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "d_31_rst");
    v(0, 4'h0, 4'h0, 4'h0, 0, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "d_31_idle");
    // Non-sticky instance
    v(1, 4'h0, 4'h0, 4'h0, 1, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "n_reset");
    v(1, 4'h4, 4'h0, 4'h0, 0, 32'h10000,    4'h4, 4'h0, 4'h0, 0, 0, "n_e1");
    v(1, 4'h4, 4'h0, 4'h0, 0, 32'h20000,    4'h4, 4'h0, 4'h0, 0, 0, "n_e2");
    v(1, 4'h4, 4'h0, 4'h0, 0, 32'h30000,    4'h0, 4'h4, 4'h4, 1, 2, "n_brk");
    v(1, 4'h0, 4'h4, 4'h0, 0, 32'h20000,    4'h4, 4'h0, 4'h0, 0, 0, "n_recover");
    v(1, 4'h4, 4'h0, 4'h0, 0, 32'h30000,    4'h0, 4'h4, 4'h4, 1, 2, "n_rebrk");
    v(1, 4'h4, 4'h0, 4'h0, 0, 32'h40000,    4'h0, 4'h4, 4'h0, 1, 2, "n_count_on");
    v(1, 4'h0, 4'h4, 4'h0, 0, 32'h30000,    4'h0, 4'h4, 4'h0, 1, 2, "n_still_brk");
    v(1, 4'h0, 4'h4, 4'h0, 0, 32'h20000,    4'h4, 4'h0, 4'h0, 0, 0, "n_leave");
    v(1, 4'h4, 4'h0, 4'h0, 1, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "n_rst");
    // Narrow counter saturation
    v(2, 4'h0, 4'h0, 4'h0, 1, 32'h0,        4'h0, 4'h0, 4'h0, 0, 0, "s_reset");
    v(2, 4'h1, 4'h0, 4'h0, 0, 32'h1,        4'h1, 4'h0, 4'h0, 0, 0, "s_e1");
    v(2, 4'h1, 4'h0, 4'h0, 0, 32'h2,        4'h1, 4'h0, 4'h0, 0, 0, "s_e2");
    v(2, 4'h1, 4'h0, 4'h0, 0, 32'h3,        4'h0, 4'h1, 4'h1, 1, 0, "s_e3");
    for (int i = 0; i < 3; i++)
      v(2, 4'h1, 4'h0, 4'h0, 0, 32'h3,      4'h0, 4'h1, 4'h0, 1, 0, "s_sat");
    v(2, 4'h0, 4'h1, 4'h0, 0, 32'h2,        4'h1, 4'h0, 4'h0, 0, 0, "s_dec");

    for (int i = 0; i < vq.size(); i++) begin
      for (int d = 0; d < 3; d++) begin
        rst_s[d] = 1'b0; err_s[d] = '0; val_s[d] = '0; clr_s[d] = '0;
      end
      rst_s[vq[i].dut] = vq[i].rst;
      err_s[vq[i].dut] = vq[i].err;
      val_s[vq[i].dut] = vq[i].valid;
      clr_s[vq[i].dut] = vq[i].clear;
      @(posedge clk);
      #1;
      case (vq[i].dut)
        0: begin a_cnt = cnt0; a_deg = deg0; a_brk = brk0; a_pls = pls0; a_any = any0; a_idx = idx0; end
        1: begin a_cnt = cnt1; a_deg = deg1; a_brk = brk1; a_pls = pls1; a_any = any1; a_idx = idx1; end
        default: begin a_cnt = {24'h0, cnt2}; a_deg = deg2; a_brk = brk2; a_pls = pls2; a_any = any2; a_idx = idx2; end
      endcase
      $display("vec %0d %s: cnt=%0h deg=%b brk=%b pls=%b any=%b idx=%0d",
               i, vq[i].name, a_cnt, a_deg, a_brk, a_pls, a_any, a_idx);
      check({vq[i].name, ".count"},    a_cnt,         vq[i].cnt);
      check({vq[i].name, ".degraded"}, 32'(a_deg),    32'(vq[i].deg));
      check({vq[i].name, ".broken"},   32'(a_brk),    32'(vq[i].brk));
      check({vq[i].name, ".pulse"},    32'(a_pls),    32'(vq[i].pls));
      check({vq[i].name, ".any"},      32'(a_any),    32'(vq[i].any));
      check({vq[i].name, ".idx"},      32'(a_idx),    32'(vq[i].idx));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_breakage_monitor_mc_ft.md
CV32E40P_BREAKAGE_MONITOR_MC_FT -- requirements
Module: cv32e40p_breakage_monitor_mc_ft

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent monitored channels, range 1..32.
REQ-002 The block SHALL have parameter COUNT_BIT, default 8: width of each channel's error counter.
REQ-003 The block SHALL have parameter INC_DEC_BIT, default 2: width of the increment and decrement step values.
REQ-004 The block SHALL have parameter INCREMENT, default 1: counter step added on an error cycle.
REQ-005 The block SHALL have parameter DECREMENT, default 1: counter step subtracted on a clean valid cycle.
REQ-006 The block SHALL have parameter BREAKING_THRESHOLD, default 3: count at or above which a channel is broken.
REQ-007 The block SHALL have parameter STICKY, default 1: 1 = broken latches until clear; 0 = broken self-recovers.
REQ-008 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-009 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 The block SHALL have port err_i, input, N_CH bits: per-channel redundancy mismatch detected this cycle.
REQ-011 The block SHALL have port valid_i, input, N_CH bits: per-channel comparison is meaningful this cycle.
REQ-012 The block SHALL have port clear_i, input, N_CH bits: per-channel counter and state clear.
REQ-013 The block SHALL have port count_o, output, N_CH*COUNT_BIT bits: channel k counter at bits [k*COUNT_BIT +: COUNT_BIT].
REQ-014 The block SHALL have port degraded_o, output, N_CH bits: channel counter is nonzero and the channel is not broken.
REQ-015 The block SHALL have port broken_o, output, N_CH bits: channel is declared broken.
REQ-016 The block SHALL have port fault_pulse_o, output, N_CH bits: one-cycle pulse on entry to BROKEN.
REQ-017 The block SHALL have port any_broken_o, output, 1 bit: OR of broken_o.
REQ-018 The block SHALL have port broken_idx_o, output, $clog2(N_CH) bits (minimum 1): lowest broken channel index; 0 if none.

Function
REQ-019 Each channel SHALL hold one COUNT_BIT-bit unsigned counter and a state register taking the values OK, DEGRADED or BROKEN.
REQ-020 The per-cycle counter update, in priority order, SHALL be: clear_i -> 0; else err_i -> count+INCREMENT; else valid_i -> count-DECREMENT; else hold.
REQ-021 err_i SHALL count regardless of valid_i.
REQ-022 Increment SHALL saturate at 2^COUNT_BIT-1 and decrement SHALL floor at 0, with no wrap in either direction.
REQ-023 The next state SHALL be derived from the next count on the same edge: count_next>=BREAKING_THRESHOLD -> BROKEN; count_next>0 -> DEGRADED; else OK.
REQ-024 With STICKY=1, a BROKEN channel SHALL remain BROKEN until clear_i or rst, and its counter SHALL freeze, ignoring err_i and valid_i.
REQ-025 With STICKY=0, a BROKEN channel SHALL keep counting and leave BROKEN on the edge where count_next<BREAKING_THRESHOLD.
REQ-026 fault_pulse_o[k] SHALL be registered high for exactly one cycle, the cycle after state[k] enters BROKEN, and SHALL re-pulse on every re-entry when STICKY=0.
REQ-027 broken_o, degraded_o and count_o SHALL be driven directly from registers, with zero combinational path from inputs.
REQ-028 any_broken_o and broken_idx_o SHALL be combinational decodes of the broken_o register bits only.
REQ-029 Channels SHALL be fully independent: activity on one channel shall never alter another channel's counter or state.
REQ-030 clear_i and err_i asserted in the same cycle SHALL give count=0 and state OK, with no fault pulse.
REQ-031 Elaboration SHALL fail with $error if any of the following holds: INCREMENT or DECREMENT >= 2^INC_DEC_BIT; INCREMENT=0; BREAKING_THRESHOLD=0; BREAKING_THRESHOLD > 2^COUNT_BIT-1.

Reset
REQ-032 When rst=1 at a rising edge, every counter SHALL become 0, every state OK, and broken_o, degraded_o, fault_pulse_o and any_broken_o 0, with broken_idx_o 0.
REQ-033 rst SHALL take priority over clear_i, err_i and valid_i.
REQ-034 rst asserted mid-operation, including in BROKEN, SHALL give the reset values on the next edge with no fault pulse.

Verification
REQ-035 The bench SHALL cover: defaults, err_i[1]=1 for 3 consecutive cycles -> count1 1,2,3; broken_o[1]=1 after 3rd edge; fault_pulse_o[1]=1 one cycle; broken_idx_o=1.
REQ-036 The bench SHALL cover: defaults, err_i[0] for 2 cycles then valid_i[0] only for 3 cycles -> count0 1,2,1,0,0; degraded_o[0] 1,1,1,0; broken_o stays 0.
REQ-037 The bench SHALL cover: STICKY=1 with ch2 broken, then valid_i[2] for 10 cycles -> count2 frozen at 3, broken_o[2]=1; clear_i[2] -> count 0, OK.
REQ-038 The bench SHALL cover: STICKY=0 with ch2 at count 3 broken, one valid_i[2] clean cycle -> count 2, broken_o[2]=0, degraded_o[2]=1; one err -> re-broken with a new fault pulse.
REQ-039 The bench SHALL cover: COUNT_BIT=2, BREAKING_THRESHOLD=3, STICKY=0, err_i every cycle for 6 cycles -> count saturates at 3, never wraps to 0.
REQ-040 The bench SHALL cover: channels 3 and 1 broken together -> broken_idx_o=1; then rst=1 one cycle -> all outputs 0 next cycle, with no pulses.
